// File: rtl/clint_timer.sv
// Core-local interruptor: memory-mapped mtime/mtimecmp, a valid/ready bus port and a one-cycle timer trap request.
// Optional msip register and o_clint_msip output when CLINT_MSIP_EN is defined.
module clint_timer #(
  parameter logic [63:0] CLINT_BASE = 64'h0200_0000,
  parameter int unsigned MTIME_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clint_req_valid,
  output logic        o_clint_req_ready,
  input  logic        i_clint_req_wen,
  input  logic [63:0] i_clint_req_addr,
  input  logic [63:0] i_clint_req_wdata,
  input  logic [7:0]  i_clint_req_wstrb,
  output logic        o_clint_rsp_valid,
  input  logic        i_clint_rsp_ready,
  output logic [63:0] o_clint_rsp_rdata,
  output logic        o_clint_rsp_err,
  input  logic        i_clint_mstatus_mie,
  input  logic        i_clint_mie_mtie,
  input  logic        i_clint_commit_valid,
  input  logic [63:0] i_clint_commit_pc,
  output logic        o_clint_timer_intr,
  output logic [63:0] o_clint_trap_pc,
  output logic        o_clint_mtip
`ifdef CLINT_MSIP_EN
  ,
  output logic        o_clint_msip
`endif
);

  localparam logic [63:0] ADDR_MTIMECMP = CLINT_BASE + 64'h4000;
  localparam logic [63:0] ADDR_MTIME    = CLINT_BASE + 64'hBFF8;
  localparam logic [15:0] DIV_LAST      = 16'(MTIME_DIV - 1);

  typedef enum logic {BUS_IDLE, BUS_RESP} bus_state_t;
  typedef enum logic [1:0] {INT_IDLE, INT_FIRE, INT_HOLD} int_state_t;

  bus_state_t  bus_state, bus_state_next;
  int_state_t  int_state, int_state_next;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [15:0] presc;
  logic        presc_wrap;
  logic        accept;
  logic        hit_mtime;
  logic        hit_mtimecmp;
  logic        wr_mtime;
  logic        wr_mtimecmp;
  logic [63:0] rd_data;
  logic        rd_err;
  logic        fire_cond;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic [63:0] trap_pc;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  strb);
    logic [63:0] res;
    res = old_val;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  assign accept       = i_clint_req_valid && (bus_state == BUS_IDLE);
  assign hit_mtime    = (i_clint_req_addr == ADDR_MTIME);
  assign hit_mtimecmp = (i_clint_req_addr == ADDR_MTIMECMP);
  assign wr_mtime     = accept && i_clint_req_wen && hit_mtime;
  assign wr_mtimecmp  = accept && i_clint_req_wen && hit_mtimecmp;
  assign presc_wrap   = (presc == DIV_LAST);

`ifdef CLINT_MSIP_EN
  logic msip;
  logic hit_msip;
  assign hit_msip     = (i_clint_req_addr == CLINT_BASE);
  assign o_clint_msip = msip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msip <= 1'b0;
    end else if (accept && i_clint_req_wen && hit_msip && i_clint_req_wstrb[0]) begin
      msip <= i_clint_req_wdata[0];
    end
  end
`endif

  // Read mux; writes always answer with zero data.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (hit_mtime) begin
      rd_data = mtime;
    end else if (hit_mtimecmp) begin
      rd_data = mtimecmp;
`ifdef CLINT_MSIP_EN
    end else if (hit_msip) begin
      rd_data = {63'b0, msip};
`endif
    end else begin
      rd_err = 1'b1;
    end
    if (i_clint_req_wen) rd_data = '0;
  end

  // A bus write to mtime overrides the prescaler increment and restarts the prescaler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime <= '0;
      presc <= '0;
    end else if (wr_mtime) begin
      mtime <= merge_bytes(mtime, i_clint_req_wdata, i_clint_req_wstrb);
      presc <= '0;
    end else if (presc_wrap) begin
      mtime <= mtime + 64'd1;
      presc <= '0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtimecmp <= '1;
    end else if (wr_mtimecmp) begin
      mtimecmp <= merge_bytes(mtimecmp, i_clint_req_wdata, i_clint_req_wstrb);
    end
  end

  assign o_clint_mtip = (mtime >= mtimecmp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_state <= BUS_IDLE;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      bus_state <= bus_state_next;
      if (accept) begin
        rsp_rdata <= rd_data;
        rsp_err   <= rd_err;
      end
    end
  end

  always_comb begin
    bus_state_next    = bus_state;
    o_clint_req_ready = 1'b0;
    o_clint_rsp_valid = 1'b0;
    case (bus_state)
      BUS_IDLE: begin
        o_clint_req_ready = 1'b1;
        if (i_clint_req_valid) bus_state_next = BUS_RESP;
      end
      BUS_RESP: begin
        o_clint_rsp_valid = 1'b1;
        if (i_clint_rsp_ready) bus_state_next = BUS_IDLE;
      end
      default: bus_state_next = BUS_IDLE;
    endcase
  end

  assign o_clint_rsp_rdata = rsp_rdata;
  assign o_clint_rsp_err   = rsp_err;

  assign fire_cond = o_clint_mtip && i_clint_mstatus_mie && i_clint_mie_mtie && i_clint_commit_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_state <= INT_IDLE;
      trap_pc   <= '0;
    end else begin
      int_state <= int_state_next;
      if ((int_state == INT_IDLE) && fire_cond) trap_pc <= i_clint_commit_pc;
    end
  end

  // HOLD gives the CSR file one cycle to clear MIE before the condition is sampled again.
  always_comb begin
    int_state_next     = int_state;
    o_clint_timer_intr = 1'b0;
    case (int_state)
      INT_IDLE: if (fire_cond) int_state_next = INT_FIRE;
      INT_FIRE: begin
        o_clint_timer_intr = 1'b1;
        int_state_next     = INT_HOLD;
      end
      INT_HOLD: int_state_next = INT_IDLE;
      default:  int_state_next = INT_IDLE;
    endcase
  end

  assign o_clint_trap_pc = trap_pc;

endmodule

// File: tb/tb_clint_timer.sv
// Self-checking bench for clint_timer: directed steps plus randomized bus traffic
// checked against a cycle-count reference model of the timer, registers and trap timing.
module tb_clint_timer;

  localparam logic [63:0] BASE   = 64'h0200_0000;
  localparam int          DIV    = 1;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'hBFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        mie = 1'b0;
  logic        mtie = 1'b0;
  logic        commit_valid = 1'b0;
  logic [63:0] commit_pc = '0;
  logic        timer_intr;
  logic [63:0] trap_pc;
  logic        mtip;
`ifdef CLINT_MSIP_EN
  logic        msip;
`endif

  always #5 clk = ~clk;

  clint_timer #(.CLINT_BASE(BASE), .MTIME_DIV(DIV)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .i_clint_req_valid   (req_valid),
    .o_clint_req_ready   (req_ready),
    .i_clint_req_wen     (req_wen),
    .i_clint_req_addr    (req_addr),
    .i_clint_req_wdata   (req_wdata),
    .i_clint_req_wstrb   (req_wstrb),
    .o_clint_rsp_valid   (rsp_valid),
    .i_clint_rsp_ready   (rsp_ready),
    .o_clint_rsp_rdata   (rsp_rdata),
    .o_clint_rsp_err     (rsp_err),
    .i_clint_mstatus_mie (mie),
    .i_clint_mie_mtie    (mtie),
    .i_clint_commit_valid(commit_valid),
    .i_clint_commit_pc   (commit_pc),
    .o_clint_timer_intr  (timer_intr),
    .o_clint_trap_pc     (trap_pc),
    .o_clint_mtip        (mtip)
`ifdef CLINT_MSIP_EN
    ,
    .o_clint_msip        (msip)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural register values plus trap timing from cycle arithmetic.
  logic [63:0] m_mtime, m_cmp, m_trap_pc, m_rdata;
  logic        m_intr, m_err;
  int          m_pre;
  longint      m_cyc, m_next_ok;
`ifdef CLINT_MSIP_EN
  logic        m_msip;
`endif

  function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                        input logic [7:0] strb);
    logic [63:0] r;
    r = old_v;
    for (int b = 0; b < 8; b++) if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mtime <= '0; m_cmp <= '1; m_pre <= 0; m_intr <= 1'b0; m_trap_pc <= '0;
      m_rdata <= '0; m_err <= 1'b0; m_cyc <= 0; m_next_ok <= 0;
`ifdef CLINT_MSIP_EN
      m_msip <= 1'b0;
`endif
    end else begin
      if (m_pre == DIV - 1) begin
        m_mtime <= m_mtime + 64'd1;
        m_pre   <= 0;
      end else begin
        m_pre <= m_pre + 1;
      end
      // The bench raises req_valid only while the port is idle, so valid here means accepted.
      if (req_valid) begin
        m_rdata <= '0;
        m_err   <= 1'b0;
        if (req_addr == A_TIME) begin
          if (req_wen) begin
            m_mtime <= merge(m_mtime, req_wdata, req_wstrb);
            m_pre   <= 0;
          end else m_rdata <= m_mtime;
        end else if (req_addr == A_CMP) begin
          if (req_wen) m_cmp <= merge(m_cmp, req_wdata, req_wstrb);
          else m_rdata <= m_cmp;
`ifdef CLINT_MSIP_EN
        end else if (req_addr == BASE) begin
          if (req_wen) begin
            if (req_wstrb[0]) m_msip <= req_wdata[0];
          end else m_rdata <= {63'b0, m_msip};
`endif
        end else begin
          m_err <= 1'b1;
        end
      end
      if ((m_mtime >= m_cmp) && mie && mtie && commit_valid && (m_cyc >= m_next_ok)) begin
        m_intr    <= 1'b1;
        m_trap_pc <= commit_pc;
        m_next_ok <= m_cyc + 3;
      end else begin
        m_intr <= 1'b0;
      end
      m_cyc <= m_cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("timer_intr", {63'b0, timer_intr}, {63'b0, m_intr});
    check("trap_pc", trap_pc, m_trap_pc);
    check("mtip", {63'b0, mtip}, {63'b0, (m_mtime >= m_cmp)});
`ifdef CLINT_MSIP_EN
    check("msip", {63'b0, msip}, {63'b0, m_msip});
`endif
  endtask

  task automatic bus(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [7:0] strb, input int hold, output logic [63:0] rdata);
    logic [63:0] er;
    logic        ee;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    rsp_ready = 1'b0;
    check("req_ready_idle", {63'b0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
    er = m_rdata;
    ee = m_err;
    rdata = rsp_rdata;
    check("rsp_valid_lat1", {63'b0, rsp_valid}, 64'd1);
    check("req_ready_busy", {63'b0, req_ready}, 64'd0);
    check("rsp_rdata", rsp_rdata, er);
    check("rsp_err", {63'b0, rsp_err}, {63'b0, ee});
    for (int i = 0; i < hold; i++) begin
      tick();
      check("rsp_valid_hold", {63'b0, rsp_valid}, 64'd1);
      check("req_ready_hold", {63'b0, req_ready}, 64'd0);
      check("rsp_rdata_hold", rsp_rdata, er);
      check("rsp_err_hold", {63'b0, rsp_err}, {63'b0, ee});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_done", {63'b0, rsp_valid}, 64'd0);
    check("req_ready_back", {63'b0, req_ready}, 64'd1);
    $display("bus wen=%0d addr=%h wdata=%h strb=%h rdata=%h err=%0d hold=%0d",
             wen, addr, wdata, strb, rdata, ee, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd, rd2, a, w;
    int k;

    // Reset values
    @(negedge clk);
    check("rst_req_ready", {63'b0, req_ready}, 64'd1);
    check("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_err", {63'b0, rsp_err}, 64'd0);
    check("rst_timer_intr", {63'b0, timer_intr}, 64'd0);
    check("rst_trap_pc", trap_pc, 64'd0);
    check("rst_mtip", {63'b0, mtip}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // mtime read twice, 10 cycles apart
    bus(1'b0, A_TIME, '0, '0, 0, rd);
    for (int i = 0; i < 8; i++) tick();
    bus(1'b0, A_TIME, '0, '0, 0, rd2);
    check("mtime_delta10", rd2 - rd, 64'd10);

    // Enabled trap: single pulse, latched PC
    mie = 1'b1; mtie = 1'b1; commit_valid = 1'b1; commit_pc = 64'h8000_0100;
    bus(1'b1, A_CMP, m_mtime + 64'd8, 8'hFF, 0, rd);
    k = 0;
    while (!m_intr && k < 60) begin tick(); k++; end
    check("pulse_seen", {63'b0, timer_intr}, 64'd1);
    check("pulse_trap_pc", trap_pc, 64'h8000_0100);
    tick();
    check("pulse_one_cycle", {63'b0, timer_intr}, 64'd0);
    tick();

    // Masked by mtie: mtip high, no pulse until mtie rises
    mtie = 1'b0;
    bus(1'b1, A_CMP, m_mtime + 64'd4, 8'hFF, 1, rd);
    for (int i = 0; i < 20; i++) tick();
    check("masked_mtip", {63'b0, mtip}, 64'd1);
    check("masked_no_intr", {63'b0, timer_intr}, 64'd0);
    mtie = 1'b1; commit_pc = 64'h8000_0200;
    tick();
    check("mtie_pulse", {63'b0, timer_intr}, 64'd1);
    check("mtie_trap_pc", trap_pc, 64'h8000_0200);
    mie = 1'b0;
    tick();

    // Byte-merged mtime write wins over the concurrent increment
    bus(1'b1, A_TIME, 64'hAAAA_AAAA_0000_0000, 8'hFF, 0, rd);
    bus(1'b1, A_TIME, 64'h0000_0000_1234_5678, 8'h0F, 0, rd);
    bus(1'b0, A_TIME, '0, '0, 0, rd);
    check("mtime_merge", rd, 64'hAAAA_AAAA_1234_5679);

    // Unmapped read with a stalled response
    bus(1'b0, BASE + 64'h0100, '0, '0, 3, rd);
    check("unmapped_rdata", rd, 64'd0);
    bus(1'b1, BASE + 64'h0100, 64'hFFFF, 8'hFF, 2, rd);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      mie = 1'($urandom_range(1, 0)); mtie = 1'($urandom_range(1, 0));
      commit_valid = 1'($urandom_range(1, 0)); commit_pc = {$urandom, $urandom};
      case ($urandom_range(3, 0))
        0: a = A_CMP;
        1: a = A_TIME;
        2: a = BASE + 64'($urandom_range(8191, 0) * 8);
        default: a = BASE;
      endcase
      w = {$urandom, $urandom};
      if (a == A_CMP && $urandom_range(1, 0) == 1) w = m_mtime + 64'($urandom_range(30, 2));
      bus(1'($urandom_range(1, 0)), a, w, 8'($urandom_range(255, 0)), $urandom_range(3, 0), rd);
      for (int i = 0; i < int'($urandom_range(5, 0)); i++) begin
        commit_valid = 1'($urandom_range(1, 0));
        tick();
      end
    end

    // Reset during FIRE
    bus(1'b1, A_TIME, 64'd0, 8'hFF, 0, rd);
    mie = 1'b1; mtie = 1'b1; commit_valid = 1'b1; commit_pc = 64'h8000_0300;
    bus(1'b1, A_CMP, m_mtime + 64'd5, 8'hFF, 0, rd);
    k = 0;
    while (!m_intr && k < 60) begin tick(); k++; end
    check("fire_before_reset", {63'b0, timer_intr}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_timer_intr", {63'b0, timer_intr}, 64'd0);
    check("arst_trap_pc", trap_pc, 64'd0);
    check("arst_mtip", {63'b0, mtip}, 64'd0);
    check("arst_req_ready", {63'b0, req_ready}, 64'd1);
    check("arst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    mie = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus(1'b0, A_CMP, '0, '0, 0, rd);
    check("arst_mtimecmp", rd, 64'hFFFF_FFFF_FFFF_FFFF);
    bus(1'b0, A_TIME, '0, '0, 0, rd);
    check("arst_mtime_small", {63'b0, (rd < 64'd8)}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
